// File: rtl/ir_tx_pkg.sv
// Shared types and constants for the NEC infrared transmitter.
// Unit multiples are in NEC units; the top scales them by UNIT_CYC.
package ir_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6
  } tx_state_e;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned RPT_SPACE_U  = 4;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned ZERO_SPACE_U = 1;
  localparam int unsigned FRAME_U      = 192;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BIT_IDX_W   = 6;
  localparam int unsigned FRAME_CNT_W = 24;

  // Standard frames carry the inverted 8-bit address; extended frames a 16-bit one.
  function automatic logic [WORD_W-1:0] make_word(input logic [15:0] addr,
                                                  input logic [7:0]  cmd,
                                                  input logic        ext_mode);
    logic [15:0] addr_field;
    addr_field = ext_mode ? addr : {~addr[7:0], addr[7:0]};
    return {~cmd, cmd, addr_field};
  endfunction

endpackage

// File: rtl/ir_tx_nec_gen_if.sv
// Command/status bundle between user logic (master) and the NEC transmitter (slave).
interface ir_tx_nec_gen_if;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        ext_mode;
  logic        repeat_en;
  logic        send;
  logic        busy;
  logic        done;
  logic        envelope;
  logic        data_out;
  logic [2:0]  tx_state;

  modport master (output addr, cmd, ext_mode, repeat_en, send,
                  input  busy, done, envelope, data_out, tx_state);
  modport slave  (input  addr, cmd, ext_mode, repeat_en, send,
                  output busy, done, envelope, data_out, tx_state);
endinterface

// File: rtl/ir_carrier_gen.sv
// Free-running IR carrier; restart forces the phase to the start of a high period.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_PERIOD = 1316,
  parameter int unsigned CARRIER_HIGH   = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic carrier
);

  localparam int unsigned CW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (restart || (cnt == CW'(CARRIER_PERIOD - 1))) cnt_nxt = '0;
  end

  // carrier is registered from the next count so it lines up with cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carrier <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      carrier <= (cnt_nxt < CW'(CARRIER_HIGH));
    end
  end

endmodule

// File: rtl/ir_tx_nec_gen.sv
// NEC infrared frame generator: leader, 32 data bits LSB first, stop mark,
// 108 ms frame period with optional repeat codes while send is held.
module ir_tx_nec_gen
  import ir_tx_pkg::*;
#(
  parameter int unsigned UNIT_CYC       = 28125,
  parameter int unsigned CARRIER_PERIOD = 1316,
  parameter int unsigned CARRIER_HIGH   = 439
) (
  input  logic            clk,
  input  logic            rst_n,
  ir_tx_nec_gen_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LEAD_MARK_U * UNIT_CYC);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_U * UNIT_CYC - 1);

  tx_state_e              state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, last;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic [FRAME_CNT_W-1:0] fcnt, fcnt_nxt;
  logic [WORD_W-1:0]      word, word_nxt;
  logic                   rpt, rpt_nxt;
  logic                   tick, env_nxt, done_nxt;
  logic                   busy, done, envelope, data_out, carrier;
  int unsigned            units;

  ir_carrier_gen #(
    .CARRIER_PERIOD (CARRIER_PERIOD),
    .CARRIER_HIGH   (CARRIER_HIGH)
  ) u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (env_nxt & ~envelope),
    .carrier (carrier)
  );

  // Next-state and datapath decode
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    word_nxt    = word;
    rpt_nxt     = rpt;
    done_nxt    = 1'b0;
    fcnt_nxt    = (fcnt == FRAME_LAST) ? fcnt : fcnt + FRAME_CNT_W'(1);

    case (state)
      ST_LEAD_MARK:  units = LEAD_MARK_U;
      ST_LEAD_SPACE: units = rpt ? RPT_SPACE_U : LEAD_SPACE_U;
      ST_BIT_SPACE:  units = word[bit_idx[4:0]] ? ONE_SPACE_U : ZERO_SPACE_U;
      default:       units = 1;
    endcase
    last = CNT_W'(units * UNIT_CYC - 1);
    tick = (cnt == last);
    cnt_nxt = (state != ST_IDLE && state != ST_GAP && !tick) ? cnt + CNT_W'(1) : '0;

    case (state)
      ST_IDLE: begin
        fcnt_nxt = '0;
        if (bus.send) begin
          state_nxt = ST_LEAD_MARK;
          word_nxt  = make_word(bus.addr, bus.cmd, bus.ext_mode);
          rpt_nxt   = 1'b0;
        end
      end
      ST_LEAD_MARK:  if (tick) state_nxt = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (tick) begin
        state_nxt   = rpt ? ST_STOP_MARK : ST_BIT_MARK;
        bit_idx_nxt = '0;
      end
      ST_BIT_MARK:   if (tick) state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (tick) begin
        if (bit_idx == BIT_IDX_W'(WORD_W - 1)) begin
          state_nxt = ST_STOP_MARK;
        end else begin
          bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
          state_nxt   = ST_BIT_MARK;
        end
      end
      ST_STOP_MARK:  if (tick) begin
        state_nxt = ST_GAP;
        done_nxt  = 1'b1;
      end
      ST_GAP: begin
        // Frame period is measured from the leader rising edge
        if (fcnt == FRAME_LAST) begin
          if (bus.send && bus.repeat_en) begin
            state_nxt = ST_LEAD_MARK;
            rpt_nxt   = 1'b1;
            fcnt_nxt  = '0;
          end else if (!bus.send) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    env_nxt = (state_nxt == ST_LEAD_MARK) || (state_nxt == ST_BIT_MARK) ||
              (state_nxt == ST_STOP_MARK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      fcnt     <= '0;
      word     <= '0;
      rpt      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      envelope <= 1'b0;
      data_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      fcnt     <= fcnt_nxt;
      word     <= word_nxt;
      rpt      <= rpt_nxt;
      busy     <= (state_nxt != ST_IDLE);
      done     <= done_nxt;
      envelope <= env_nxt;
      data_out <= envelope & carrier & env_nxt;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.envelope = envelope;
  assign bus.data_out = data_out;
  assign bus.tx_state = state;

endmodule

// File: doc/ir_tx_nec_gen.md
Name: ir_tx_nec_gen

Overview:
Parametrised next-generation NEC infrared transmitter for the DE10 IR path. It produces standard NEC frames (8-bit address) or extended NEC frames (16-bit address), with optional NEC repeat codes while send is held. Carrier frequency, carrier duty and symbol unit are parameters. It sits between the user command logic and the IR LED driver pin, and exports both the modulated output and the bare envelope.

Parameters:
UNIT_CYC, 28125, clk cycles per NEC unit (562.5 us at 50 MHz); every timing is an integer multiple of it.
CARRIER_PERIOD, 1316, clk cycles per carrier period (about 38 kHz at 50 MHz).
CARRIER_HIGH, 439, carrier high cycles per period (1/3 duty); legal range 1..CARRIER_PERIOD-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  16  address; only [7:0] is used when ext_mode=0
cmd  in  8  command
ext_mode  in  1  0: word = {~cmd, cmd, ~addr[7:0], addr[7:0]}; 1: word = {~cmd, cmd, addr[15:0]}
repeat_en  in  1  enable repeat codes while send is held
send  in  1  level request
busy  out  1  high from acceptance until return to IDLE
done  out  1  one-cycle pulse at the end of each frame or repeat stop mark
envelope  out  1  unmodulated mark/space
data_out  out  1  envelope AND carrier
tx_state  out  3  current state encoding

Behaviour:
- Reset (asynchronous, immediate): busy=0, done=0, envelope=0, data_out=0, tx_state=IDLE. All counters clear. Reset mid-frame abandons the frame.
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- IDLE, send=1 at an edge:
  - Latch the 32-bit word, latch ext_mode.
  - busy=1 and envelope=1 on that same edge; go to LEAD_MARK.
  - Start the frame-period counter at 0.
- Inputs are ignored while busy; the latched word is not affected by later changes.
- Durations are exact counts of cycles with envelope at the given level:
  - LEAD_MARK: 16 units high.
  - LEAD_SPACE: 8 units low (full frame) or 4 units low (repeat).
  - BIT_MARK: 1 unit high.
  - BIT_SPACE: 1 unit low for a 0, 3 units low for a 1.
  - STOP_MARK: 1 unit high.
- Bits are sent LSB first, 32 bits total. A 6-bit bit counter stops after bit 31; the next state is STOP_MARK.
- Repeat frame: LEAD_MARK, then a 4-unit LEAD_SPACE, then STOP_MARK directly (no data bits).
- End of STOP_MARK: envelope=0, done pulses for exactly 1 cycle, go to GAP.
- GAP holds until the frame-period counter reaches 192*UNIT_CYC-1 (108 ms, measured from the leader rising edge). Then:
  - send=1 and repeat_en=1: restart the period counter and start a repeat LEAD_MARK.
  - send=1 and repeat_en=0: remain in GAP with busy=1 until send=0.
  - send=0: go to IDLE with busy=0.
- Frame-period counter is 24 bits; it saturates at its terminal value and does not wrap.
- Carrier: counter runs 0..CARRIER_PERIOD-1; carrier=1 while count < CARRIER_HIGH. The counter restarts at 0 on every envelope rising edge, so each mark begins with a full high phase.
- data_out is registered: data_out = envelope AND carrier, with one-cycle alignment to envelope. It is 0 whenever envelope is 0.
- Asserting send again while in IDLE after completion starts a new full frame, never a repeat.

Decomposition:
- Package ir_tx_pkg holds:
  - the state enum;
  - unit multiples LEAD_MARK_U=16, LEAD_SPACE_U=8, RPT_SPACE_U=4, ONE_SPACE_U=3, ZERO_SPACE_U=1, FRAME_U=192;
  - a word-assembly function taking (addr, cmd, ext_mode).
- One sub-module, ir_carrier_gen, parametrised by CARRIER_PERIOD and CARRIER_HIGH, with a restart input and a carrier output.

Test Plan:
All scenarios use UNIT_CYC=10, CARRIER_PERIOD=4, CARRIER_HIGH=1.
1. Standard frame: addr=0x005A, cmd=0x3C, ext_mode=0, one-cycle send pulse -> word 0xC33CA55A; envelope shows 160 high, 80 low, then 32 bits (16 ones at 10 high + 30 low, 16 zeros at 10 high + 10 low), then 10 high; done pulses 1210 cycles after acceptance; busy falls at cycle 1920.
2. Extended frame: addr=0x1234, cmd=0x01, ext_mode=1 -> bits match 0xFE011234 LSB first; a change to addr during busy has no effect.
3. Repeat: send held, repeat_en=1 -> a repeat starts at cycle 1920 and again at 3840 (160 high, 40 low, 10 high), with done at each; release send during the second repeat -> IDLE at cycle 5760.
4. No repeat: send held, repeat_en=0 -> a single frame; state stays GAP with busy=1 past cycle 1920; send falls -> IDLE next edge, with no envelope activity.
5. Carrier: during every mark data_out follows 1,0,0,0 from the mark's first cycle (with one-cycle registration); data_out stays 0 throughout spaces and GAP.
6. Async reset asserted mid BIT_SPACE -> all outputs 0 immediately; after release, a new send yields a complete correct frame as in scenario 1.
